// File: rtl/alu_defs.sv
// Shared op codes and FSM state encoding for the registered ALU.
package alu_defs;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_INC = 3'b010;
  localparam logic [2:0] OP_NEG = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle datapath: operand muxing, conditional complement,
// WIDTH+1 bit adder, logic unit and flag generation.
module alu_core
  import alu_defs::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] r,
  output logic             zero,
  output logic             carry,
  output logic             sign,
  output logic             overflow
);

  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] low;

  // Every arithmetic op is x + y + cin; NEG and INC feed b through x.
  always_comb begin
    x   = '0;
    y   = '0;
    cin = 1'b0;
    case (op)
      OP_ADD: begin x = a;  y = b;               end
      OP_SUB: begin x = a;  y = ~b; cin = 1'b1;  end
      OP_INC: begin x = b;            cin = 1'b1; end
      OP_NEG: begin x = ~b;           cin = 1'b1; end
      default: ;
    endcase
  end

  assign sum = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
  // low[WIDTH-1] is the carry into the MSB.
  assign low = {1'b0, x[WIDTH-2:0]} + {1'b0, y[WIDTH-2:0]} + {{(WIDTH-1){1'b0}}, cin};

  always_comb begin
    r        = sum[WIDTH-1:0];
    carry    = sum[WIDTH];
    overflow = low[WIDTH-1] ^ sum[WIDTH];
    case (op)
      OP_AND: begin r = a & b; carry = 1'b0; overflow = 1'b0; end
      OP_OR:  begin r = a | b; carry = 1'b0; overflow = 1'b0; end
      OP_XOR: begin r = a ^ b; carry = 1'b0; overflow = 1'b0; end
      OP_MUL: begin r = '0;    carry = 1'b0; overflow = 1'b0; end
      default: ;
    endcase
  end

  assign zero = ~|r;
  assign sign = r[WIDTH-1];

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with start/busy/done handshake and a WIDTH-iteration
// unsigned shift-add multiplier.
module alu_seq
  import alu_defs::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] r_hi,
  output logic             zero,
  output logic             carry,
  output logic             sign,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  state_t             state;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   count;
  logic               accept;

  logic [WIDTH-1:0]   core_r;
  logic               core_zero;
  logic               core_carry;
  logic               core_sign;
  logic               core_overflow;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .op       (op),
    .a        (a),
    .b        (b),
    .r        (core_r),
    .zero     (core_zero),
    .carry    (core_carry),
    .sign     (core_sign),
    .overflow (core_overflow)
  );

  assign accept   = start && !busy;
  assign acc_next = mplier[0] ? acc + mcand : acc;

  // Multiplier datapath: only meaningful while in ST_MUL, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept && op == OP_MUL) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
      count  <= CNT_LOAD;
    end else if (state == ST_MUL) begin
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      acc    <= acc_next;
      count  <= count - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      r        <= '0;
      r_hi     <= '0;
      zero     <= 1'b0;
      carry    <= 1'b0;
      sign     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (op == OP_MUL) begin
              state <= ST_MUL;
              busy  <= 1'b1;
            end else begin
              r        <= core_r;
              r_hi     <= '0;
              zero     <= core_zero;
              carry    <= core_carry;
              sign     <= core_sign;
              overflow <= core_overflow;
              done     <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          // Last iteration: publish acc_next directly so done lands WIDTH edges after accept.
          if (count == CNT_LAST) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b1;
            r        <= acc_next[WIDTH-1:0];
            r_hi     <= acc_next[2*WIDTH-1:WIDTH];
            zero     <= ~|acc_next;
            carry    <= |acc_next[2*WIDTH-1:WIDTH];
            sign     <= acc_next[WIDTH-1];
            overflow <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed table, randomized ops against an arithmetic
// model, and multi-cycle handshake/reset sequences at WIDTH=4 and WIDTH=8.
module tb_alu_seq;
  import alu_defs::*;

  localparam int W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a, b, r, r_hi;
  logic         zero, carry, sign, overflow, busy, done;

  logic         start8;
  logic [2:0]   op8;
  logic [7:0]   a8, b8, r8, r_hi8;
  logic         zero8, carry8, sign8, overflow8, busy8, done8;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .r(r), .r_hi(r_hi), .zero(zero), .carry(carry), .sign(sign),
    .overflow(overflow), .busy(busy), .done(done)
  );

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
    .r(r8), .r_hi(r_hi8), .zero(zero8), .carry(carry8), .sign(sign8),
    .overflow(overflow8), .busy(busy8), .done(done8)
  );

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic [W-1:0] r_hi;
    logic         zero;
    logic         carry;
    logic         sign;
    logic         ovf;
  } vec_t;

  vec_t vecs[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] o, input logic [W-1:0] ia, ib, er, erh,
                              input logic ez, ec, es, eo);
    vec_t v;
    v.op = o; v.a = ia; v.b = ib; v.r = er; v.r_hi = erh;
    v.zero = ez; v.carry = ec; v.sign = es; v.ovf = eo;
    return v;
  endfunction

  // Reference: plain integer arithmetic on unsigned and signed readings of the operands.
  function automatic vec_t model(input logic [2:0] o, input logic [W-1:0] ia, ib);
    int m = 1 << W;
    int x = int'(ia);
    int y = int'(ib);
    int sx, sy;
    int res = 0;
    int ss = 0;
    int p = 0;
    vec_t e;
    sx = (x >= m / 2) ? x - m : x;
    sy = (y >= m / 2) ? y - m : y;
    e.op = o; e.a = ia; e.b = ib; e.r_hi = '0; e.carry = 1'b0; e.ovf = 1'b0;
    case (o)
      OP_ADD: begin res = x + y; e.carry = (res >= m); ss = sx + sy; e.ovf = (ss < -m / 2) || (ss >= m / 2); end
      OP_SUB: begin res = x - y; e.carry = (x >= y);   ss = sx - sy; e.ovf = (ss < -m / 2) || (ss >= m / 2); end
      OP_INC: begin res = y + 1; e.carry = (res >= m); ss = sy + 1;  e.ovf = (ss >= m / 2); end
      OP_NEG: begin res = -y;    e.carry = (y == 0);   ss = -sy;     e.ovf = (ss >= m / 2); end
      OP_AND: res = x & y;
      OP_OR:  res = x | y;
      OP_XOR: res = x ^ y;
      default: begin p = x * y; res = p; e.r_hi = W'(p / m); e.carry = (p >= m); end
    endcase
    res = ((res % m) + m) % m;
    e.r = W'(res);
    e.zero = (o == OP_MUL) ? (p == 0) : (res == 0);
    e.sign = (res >= m / 2);
    return e;
  endfunction

  task automatic check_outs(input string tag, input vec_t e);
    chk({tag, ".r"},        32'(r),        32'(e.r));
    chk({tag, ".r_hi"},     32'(r_hi),     32'(e.r_hi));
    chk({tag, ".zero"},     32'(zero),     32'(e.zero));
    chk({tag, ".carry"},    32'(carry),    32'(e.carry));
    chk({tag, ".sign"},     32'(sign),     32'(e.sign));
    chk({tag, ".overflow"}, 32'(overflow), 32'(e.ovf));
  endtask

  // Issue one op, wait (bounded) for done, check latency, outputs and single-cycle done.
  task automatic run_op(input string tag, input vec_t e);
    int lat;
    @(negedge clk);
    start = 1'b1; op = e.op; a = e.a; b = e.b;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 20) begin
      chk({tag, ".busy_wait"}, 32'(busy), 32'(e.op == OP_MUL));
      @(negedge clk);
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), (e.op == OP_MUL) ? 32'(W + 1) : 32'd1);
    chk({tag, ".busy_done"}, 32'(busy), 32'd0);
    check_outs(tag, e);
    @(negedge clk);
    chk({tag, ".done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int ndone;
    vec_t e;

    reset = 1'b1; start = 1'b0; op = OP_ADD; a = '0; b = '0;
    start8 = 1'b0; op8 = OP_ADD; a8 = '0; b8 = '0;

    vecs.push_back(mk(OP_ADD, 4'd7,  4'd9,  4'h0, 4'h0, 1, 1, 0, 0));
    vecs.push_back(mk(OP_ADD, 4'd7,  4'd1,  4'h8, 4'h0, 0, 0, 1, 1));
    vecs.push_back(mk(OP_SUB, 4'd3,  4'd5,  4'hE, 4'h0, 0, 0, 1, 0));
    vecs.push_back(mk(OP_NEG, 4'd0,  4'd0,  4'h0, 4'h0, 1, 1, 0, 0));
    vecs.push_back(mk(OP_XOR, 4'hA,  4'hF,  4'h5, 4'h0, 0, 0, 0, 0));
    vecs.push_back(mk(OP_AND, 4'hC,  4'hA,  4'h8, 4'h0, 0, 0, 1, 0));
    vecs.push_back(mk(OP_OR,  4'h5,  4'hA,  4'hF, 4'h0, 0, 0, 1, 0));
    vecs.push_back(mk(OP_INC, 4'h0,  4'hF,  4'h0, 4'h0, 1, 1, 0, 0));
    vecs.push_back(mk(OP_INC, 4'h0,  4'h7,  4'h8, 4'h0, 0, 0, 1, 1));
    vecs.push_back(mk(OP_NEG, 4'h0,  4'h8,  4'h8, 4'h0, 0, 0, 1, 1));
    vecs.push_back(mk(OP_SUB, 4'h8,  4'h1,  4'h7, 4'h0, 0, 1, 0, 1));
    vecs.push_back(mk(OP_SUB, 4'h5,  4'h5,  4'h0, 4'h0, 1, 1, 0, 0));
    vecs.push_back(mk(OP_MUL, 4'd13, 4'd11, 4'hF, 4'h8, 0, 1, 1, 0));
    vecs.push_back(mk(OP_MUL, 4'd0,  4'd9,  4'h0, 4'h0, 1, 0, 0, 0));
    vecs.push_back(mk(OP_MUL, 4'hF,  4'hF,  4'h1, 4'hE, 0, 1, 0, 0));

    // Reset state
    repeat (2) @(negedge clk);
    check_outs("reset", mk(OP_ADD, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0));
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.done", 32'(done), 32'd0);
    chk("reset.r8",   32'(r8),   32'd0);
    reset = 1'b0;

    foreach (vecs[i]) run_op($sformatf("vec%0d", i), vecs[i]);

    for (int i = 0; i < 150; i++) begin
      e = model(3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
      run_op($sformatf("rnd%0d", i), e);
    end

    // MUL with an ADD start pulsed while busy: ignored, no second done
    @(negedge clk);
    start = 1'b1; op = OP_MUL; a = 4'd13; b = 4'd11;
    @(negedge clk);
    start = 1'b0; lat = 1;
    chk("midmul.busy", 32'(busy), 32'd1);
    @(negedge clk);
    lat = 2; start = 1'b1; op = OP_ADD; a = 4'd1; b = 4'd1;
    @(negedge clk);
    start = 1'b0; lat = 3;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("midmul.latency", 32'(lat), 32'(W + 1));
    check_outs("midmul", mk(OP_MUL, 4'd13, 4'd11, 4'hF, 4'h8, 0, 1, 1, 0));
    @(negedge clk);
    chk("midmul.no_second_done", 32'(done), 32'd0);
    chk("midmul.r_held", 32'(r), 32'hF);

    // Asynchronous reset after two MUL iterations
    @(negedge clk);
    start = 1'b1; op = OP_MUL; a = 4'd13; b = 4'd11;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_outs("abort", mk(OP_ADD, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0));
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort.no_done", 32'(ndone), 32'd0);
    run_op("after_abort", mk(OP_MUL, 4'd3, 4'd5, 4'hF, 4'h0, 0, 0, 1, 0));

    // WIDTH=8: MUL 255*255, then ADD issued in the done cycle
    @(negedge clk);
    start8 = 1'b1; op8 = OP_MUL; a8 = 8'hFF; b8 = 8'hFF;
    @(negedge clk);
    start8 = 1'b0; lat = 1;
    while (!done8 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    chk("w8mul.latency", 32'(lat), 32'd9);
    chk("w8mul.r",     32'(r8),     32'h01);
    chk("w8mul.r_hi",  32'(r_hi8),  32'hFE);
    chk("w8mul.carry", 32'(carry8), 32'd1);
    chk("w8mul.zero",  32'(zero8),  32'd0);
    start8 = 1'b1; op8 = OP_ADD; a8 = 8'h80; b8 = 8'h80;
    @(negedge clk);
    start8 = 1'b0;
    chk("w8add.done",     32'(done8),     32'd1);
    chk("w8add.busy",     32'(busy8),     32'd0);
    chk("w8add.r",        32'(r8),        32'h00);
    chk("w8add.r_hi",     32'(r_hi8),     32'h00);
    chk("w8add.zero",     32'(zero8),     32'd1);
    chk("w8add.carry",    32'(carry8),    32'd1);
    chk("w8add.sign",     32'(sign8),     32'd0);
    chk("w8add.overflow", 32'(overflow8), 32'd1);
    @(negedge clk);
    chk("w8add.done_pulse", 32'(done8), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
